// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode constants and slave state encoding
package spi_pkg;

   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b0;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_t;

endpackage

// File: rtl/spi_slave_responder_if.sv
// rtl/spi_slave_responder_if.sv - PU-side and SPI-pin bundle for the slave responder
interface spi_slave_responder_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  wr;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  ready;
   logic                  busy;
   logic                  aborted;
   logic                  mosi;
   logic                  miso;
   logic                  sclk;
   logic                  cs;

   modport master (
      output data_in, wr, mosi, sclk, cs,
      input  data_out, ready, busy, aborted, miso
   );

   modport slave (
      input  data_in, wr, mosi, sclk, cs,
      output data_out, ready, busy, aborted, miso
   );
endinterface

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - 2-flop synchronizer with one-clk rise/fall detect
module spi_input_sync #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);
   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
         r_prev <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - oversampled SPI mode-0 slave, MSB first, full duplex
// Received words pulse ready; tx word comes from a PU-loaded holding register.
module spi_slave_responder
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   spi_slave_responder_if.slave   bus
);
   localparam int            CW       = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   spi_state_t            r_state;
   spi_state_t            w_next_state;
   logic [DATA_WIDTH-1:0] r_tx_hold;
   logic [DATA_WIDTH-1:0] r_tx_shift;
   logic [DATA_WIDTH-1:0] r_rx_shift;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic [DATA_WIDTH-1:0] w_tx_next;
   logic [DATA_WIDTH-1:0] w_rx_next;
   logic [CW-1:0]         r_cnt;
   logic                  r_ready;
   logic                  r_aborted;
   logic [1:0]            r_arm_pipe;
   logic                  r_armed;
   logic                  w_sclk_rise;
   logic                  w_sclk_fall;
   logic                  w_cs_sync;
   logic                  w_cs_rise;
   logic                  w_cs_fall;
   logic                  w_mosi_sync;
   logic                  w_start;

   spi_input_sync #(.RESET_VAL(CPOL)) u_sclk_sync (
      .clk(clk), .rst(rst), .i_d(bus.sclk),
      .o_sync(), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
   );

   spi_input_sync #(.RESET_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .i_d(bus.cs),
      .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
   );

   spi_input_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
      .clk(clk), .rst(rst), .i_d(bus.mosi),
      .o_sync(w_mosi_sync), .o_rise(), .o_fall()
   );

   // A same-cycle wr wins over the held word whenever tx_shift is (re)loaded.
   assign w_tx_next = bus.wr ? bus.data_in : r_tx_hold;
   assign w_rx_next = {r_rx_shift[DATA_WIDTH-2:0], w_mosi_sync};
   assign w_start   = w_cs_fall & r_armed;

   // cs is only trusted once real samples have filled the synchronizer and read high,
   // so a cs already low when reset releases cannot start a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_arm_pipe <= 2'b00;
         r_armed    <= 1'b0;
      end else begin
         r_arm_pipe <= {r_arm_pipe[0], 1'b1};
         if (r_arm_pipe[1] && w_cs_sync) begin
            r_armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_hold <= '0;
      end else if (bus.wr) begin
         r_tx_hold <= bus.data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_start)   w_next_state = SHIFT;
         SHIFT:   if (w_cs_rise) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.miso = 1'b0;
      if (r_state == SHIFT) begin
         bus.busy = 1'b1;
         bus.miso = r_tx_shift[DATA_WIDTH-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_data_out <= '0;
         r_cnt      <= '0;
         r_ready    <= 1'b0;
         r_aborted  <= 1'b0;
      end else begin
         r_ready   <= 1'b0;
         r_aborted <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_tx_shift <= w_tx_next;
                  r_rx_shift <= '0;
                  r_cnt      <= '0;
               end
            end
            SHIFT: begin
               // cs_rise takes priority over any sclk edge seen in the same cycle.
               if (w_cs_rise) begin
                  r_aborted <= (r_cnt != '0);
                  r_cnt     <= '0;
               end else begin
                  if (w_sclk_rise) begin
                     r_rx_shift <= w_rx_next;
                     if (r_cnt == LAST_BIT) begin
                        r_data_out <= w_rx_next;
                        r_ready    <= 1'b1;
                        r_cnt      <= '0;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
                  if (w_sclk_fall) begin
                     if (r_cnt != '0) begin
                        r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                     end else begin
                        r_tx_shift <= w_tx_next;
                     end
                  end
               end
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   assign bus.data_out = r_data_out;
   assign bus.ready    = r_ready;
   assign bus.aborted  = r_aborted;
endmodule
